// File: rtl/fc_seq_pkg.sv
// Shared types for the fc chain sequencer: FSM state encoding and pass counter width.
package fc_seq_pkg;

    localparam int unsigned PASS_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FWD_ISSUE,
        FWD_WAIT,
        BWD_ISSUE,
        BWD_WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fc_seq_osc_div.sv
// Clock-enable square wave: toggles every OSC_DIV enabled cycles, held at 0 and
// divider cleared whenever the enable is low.
module fc_seq_osc_div #(
    parameter int unsigned OSC_DIV = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    output logic osc_out
);

    localparam int unsigned CW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          osc_q, osc_d;

    always_comb begin
        cnt_d = cnt_q;
        osc_d = osc_q;
        if (!en_in) begin
            cnt_d = '0;
            osc_d = 1'b0;
        end else if (cnt_q == CW'(OSC_DIV - 1)) begin
            cnt_d = '0;
            osc_d = ~osc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            osc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            osc_q <= osc_d;
        end
    end

    assign osc_out = osc_q;

endmodule

// File: rtl/fc_chain_sequencer.sv
// Forward (and optionally backward) sweep sequencer over a chain of fc layers.
// Define FC_SEQ_WATCHDOG_EN to add a per-wait watchdog that flags err_out and ends the pass.
module fc_chain_sequencer
    import fc_seq_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned OSC_DIV    = 4,
    parameter int unsigned WD_CYCLES  = 65535
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic                          train_in,
    input  logic [NUM_LAYERS-1:0]         layer_done_in,
    output logic [NUM_LAYERS-1:0]         fd_prop_out,
    output logic [NUM_LAYERS-1:0]         bk_prop_out,
    output logic                          oscillator_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic [$clog2(NUM_LAYERS):0]   cur_layer_out,
    output logic [PASS_CNT_W-1:0]         pass_cnt_out,
    output logic                          err_out
);

    localparam int unsigned LW = $clog2(NUM_LAYERS) + 1;

    if (NUM_LAYERS < 1 || OSC_DIV < 1 || WD_CYCLES < 1) begin : g_param_err
        $error("fc_chain_sequencer: NUM_LAYERS, OSC_DIV and WD_CYCLES must be >= 1");
    end

    function automatic logic [NUM_LAYERS-1:0] layer_bit(input logic [LW-1:0] idx);
        return NUM_LAYERS'(1) << idx;
    endfunction

    seq_state_t              state_q, state_d;
    logic [LW-1:0]           layer_q, layer_d;
    logic                    train_q, train_d;
    logic [NUM_LAYERS-1:0]   fd_q, fd_d, bk_q, bk_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [PASS_CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic                    act_done, wd_expire;

    // Only the layer currently being waited on may complete the wait.
    assign act_done = |(layer_done_in & layer_bit(layer_q));

`ifdef FC_SEQ_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_expire = (wd_cnt_q == WDW'(WD_CYCLES - 1));

    always_comb begin
        wd_cnt_d = '0;
        if (state_q == FWD_WAIT || state_q == BWD_WAIT) wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        train_d    = train_q;
        fd_d       = '0;
        bk_d       = '0;
        done_d     = 1'b0;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = FWD_ISSUE;
                    layer_d = '0;
                    train_d = train_in;
                    err_d   = 1'b0;
                    fd_d    = layer_bit('0);
                end
            end
            FWD_ISSUE: state_d = FWD_WAIT;
            FWD_WAIT: begin
                if (act_done) begin
                    if (layer_q < LW'(NUM_LAYERS - 1)) begin
                        state_d = FWD_ISSUE;
                        layer_d = layer_q + 1'b1;
                        fd_d    = layer_bit(layer_q + 1'b1);
                    end else if (train_q) begin
                        state_d = BWD_ISSUE;
                        bk_d    = layer_bit(layer_q);
                    end else begin
                        state_d = DONE;
                    end
                end else if (wd_expire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            BWD_ISSUE: state_d = BWD_WAIT;
            BWD_WAIT: begin
                if (act_done) begin
                    if (layer_q != '0) begin
                        state_d = BWD_ISSUE;
                        layer_d = layer_q - 1'b1;
                        bk_d    = layer_bit(layer_q - 1'b1);
                    end else begin
                        state_d = DONE;
                    end
                end else if (wd_expire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                layer_d = '0;
            end
            default: state_d = IDLE;
        endcase
        // DONE lasts exactly one cycle, so entering it is the single pass-end event.
        if (state_d == DONE) begin
            done_d     = 1'b1;
            pass_cnt_d = pass_cnt_q + 1'b1;
        end
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            train_q    <= 1'b0;
            fd_q       <= '0;
            bk_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            train_q    <= train_d;
            fd_q       <= fd_d;
            bk_q       <= bk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
        end
    end

    fc_seq_osc_div #(
        .OSC_DIV(OSC_DIV)
    ) u_osc_div (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en_in  (busy_q),
        .osc_out(oscillator_out)
    );

    assign fd_prop_out   = fd_q;
    assign bk_prop_out   = bk_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign cur_layer_out = layer_q;
    assign pass_cnt_out  = pass_cnt_q;
    assign err_out       = err_q;

endmodule
